// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote, parity/framing flags, overrun and break detection
module uart_rx_os #(
    parameter int CLOCK_FREQ = 38400000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 soft_reset,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] SC_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SC_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SC_END = SW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_os: CLOCK_FREQ too low for BAUD_RATE * OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
        $error("uart_rx_os: unsupported frame format");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        div_q, div_d;
    logic [1:0]           sync_q, sync_d;
    logic [SW-1:0]        sc_q, sc_d;
    logic [3:0]           bit_q, bit_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 ones_q, ones_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;

    logic tick;
    logic rx_s;
    logic bit_val;
    logic frame_done;
    logic stop_ferr;
    logic is_break;

    always_comb begin
        tick   = (div_q == CW'(DIV - 1));
        div_d  = tick ? '0 : div_q + CW'(1);
        sync_d = {sync_q[0], rx};
    end

    assign rx_s    = sync_q[1];
    assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        bit_d      = bit_q;
        smp_d      = smp_q;
        shreg_d    = shreg_q;
        ones_d     = ones_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        ovr_d      = ovr_q;
        brk_d      = 1'b0;
        valid_d    = valid_q & ~ready;
        frame_done = 1'b0;
        stop_ferr  = ferr_q | ~bit_val;
        // ones_q covers every earlier bit of the frame, so break needs only the final stop bit low too
        is_break   = ~ones_q & ~bit_val;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        sc_d    = '0;
                        bit_d   = '0;
                        ones_d  = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                        sc_d    = '0;
                    end
                end
                default: begin
                    sc_d = sc_q + SW'(1);
                    if (sc_q == SC_LO)  smp_d[0] = rx_s;
                    if (sc_q == SC_MID) smp_d[1] = rx_s;
                    if (sc_q == SC_HI) begin
                        case (state_q)
                            S_START: begin
                                if (bit_val) begin
                                    state_d = S_IDLE;
                                    sc_d    = '0;
                                end
                            end
                            S_DATA: begin
                                shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                                ones_d  = ones_q | bit_val;
                            end
                            S_PARITY: begin
                                ones_d = ones_q | bit_val;
                                perr_d = (PARITY == 1) ? ~(^shreg_q ^ bit_val) : (^shreg_q ^ bit_val);
                            end
                            S_STOP: begin
                                ones_d     = ones_q | bit_val;
                                ferr_d     = stop_ferr;
                                frame_done = (bit_q == 4'(STOP_BITS - 1));
                            end
                            default: ;
                        endcase
                    end
                    if (sc_q == SC_END) begin
                        sc_d  = '0;
                        bit_d = bit_q + 4'd1;
                        case (state_q)
                            S_START: begin
                                state_d = S_DATA;
                                bit_d   = '0;
                            end
                            S_DATA: begin
                                if (bit_q == 4'(DATA_BITS - 1)) begin
                                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                                    bit_d   = '0;
                                end
                            end
                            S_PARITY: begin
                                state_d = S_STOP;
                                bit_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end

        // Completion at the last stop-bit mid tick lets a back-to-back start edge be caught
        if (frame_done) begin
            sc_d = '0;
            if (is_break) begin
                brk_d   = 1'b1;
                state_d = S_WAIT_HIGH;
            end else begin
                state_d = stop_ferr ? S_WAIT_HIGH : S_IDLE;
                if (!valid_q || ready) begin
                    data_d  = shreg_q;
                    pe_d    = perr_q;
                    fe_d    = stop_ferr;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end

        if (soft_reset) begin
            state_d = S_IDLE;
            sc_d    = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            sync_q  <= 2'b11;
            sc_q    <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shreg_q <= '0;
            ones_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sync_q  <= sync_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shreg_q <= shreg_d;
            ones_q  <= ones_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver with configurable data width, parity, stop bits and majority-vote sampling. It is the next generation of the team's 9600-baud 8N1 receiver. It adds:
- a 2-flop input synchronizer
- a valid/ready output handshake
- per-word parity and framing error flags
- sticky overrun and break detection

It sits between the board `rx` pin and the command/packet parser, in the same clock domain as the parser.

## Interface
- `CLOCK_FREQ`, 38400000: clk frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate.
- `OVERSAMPLE`, 16: sample ticks per bit; even, ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `soft_reset` in 1: synchronous clear; aborts the frame in progress, clears `valid`, `overrun` and the error flags.
- `data` out DATA_BITS: received word, LSB = first bit on the line.
- `valid` out 1: `data`, `parity_err` and `frame_err` are held and valid.
- `ready` in 1: consumer accepts the word when `valid & ready`.
- `parity_err` out 1: held word failed the parity check (always 0 when PARITY = 0).
- `frame_err` out 1: held word had at least one stop bit sampled low.
- `overrun` out 1: sticky; a completed word was dropped because the buffer was full.
- `break_det` out 1: one-cycle pulse on a break condition.
- `busy` out 1: receiver is not in IDLE.

## Operation
- **Synchronizer:** 2 flops, reset to 1; `rx_s` is its output. All logic uses `rx_s`.
- **Tick generator:**
  - Divisor DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE), integer truncation; elaboration fails if DIV < 1.
  - Free-running counter 0..DIV-1; `tick` is asserted for one clk when the counter equals DIV-1.
- **Sample counter (`sc`):** 0..OVERSAMPLE-1, advances on `tick` and resets to 0 on every state entry.
- **Bit value:** majority of `rx_s` at `sc` = OS/2-1, OS/2 and OS/2+1. The bit decision is taken on the tick where `sc` = OS/2+1 (the "mid tick"); the state advances at `sc` = OS-1.
- **State machine:**
  - IDLE: on a `tick` with `rx_s` = 0, go to START with `sc` = 0.
  - START: at the mid tick, a majority of 1 is a false start and returns to IDLE with no flags. Otherwise continue; at `sc` = OS-1 go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: compute the check bit over the data bits. Odd parity: data plus parity bit has an odd number of ones; even: an even number. A mismatch sets the pending `perr`.
  - STOP: sample STOP_BITS bits; any 0 sets the pending `ferr`. The frame completes at the mid tick of the final stop bit; it does not wait for the end of that bit.
  - WAIT_HIGH: entered after a break or a frame error; returns to IDLE on the first `tick` with `rx_s` = 1.
- **Break:** all data bits, the parity bit (if present) and all stop bits are 0.
  - Pulse `break_det`; do not deliver the word.
  - `frame_err` and `overrun` are not changed.
  - Go to WAIT_HIGH.
- **Commit**, at frame completion and not a break:
  - If `valid` = 0, or `valid & ready` in the same cycle: load `data`, `parity_err` ← `perr`, `frame_err` ← `ferr`, and set `valid`.
  - Otherwise set `overrun`, drop the new word, and keep the held word unchanged.
- **Handshake:** `valid` falls the cycle after `valid & ready` unless a commit occurs in that same cycle. `data` is stable while `valid` = 1.
- **soft_reset:** has priority over commit and over ready.
  - Next cycle: FSM in IDLE, `valid` = 0, `overrun` = 0, `parity_err` = 0, `frame_err` = 0.
  - The tick counter and synchronizer are not cleared.
- **Reset mid-frame:** all state returns to reset values immediately. Line activity in progress after reset is released is treated as IDLE, so a low line may falsely start a frame.

## Timing
- **Reset values:** `data` 0, `valid` 0, `parity_err` 0, `frame_err` 0, `overrun` 0, `break_det` 0, `busy` 0, `rx_s` 1, FSM IDLE.
- **Start detect:** 2 clk of synchronizer, plus up to 1 tick of start detection.
- **Commit latency:** `valid` rises 1 clk after the final stop-bit mid tick.
- **Back-to-back:** a new start edge is recognised from the tick after commit, so frames with a single stop bit and no idle gap are received.
- **`break_det`:** high for exactly 1 clk, at the final stop-bit mid tick.
- **`busy`:** high from the clk after leaving IDLE until the clk after re-entering IDLE.

## Test plan
Bench parameters: CLOCK_FREQ = 1600000, BAUD_RATE = 100000, OVERSAMPLE = 16 (DIV = 1). `ready` is held high unless noted.
- **8N1 word:** send 0xA5 → `valid` for 1 clk with `data` = 0xA5, both error flags 0; `valid` rises 1 clk after the stop-bit mid tick.
- **Even parity, bad bit:** PARITY = 2, send 0x3C with parity bit 1 → `data` = 0x3C with `parity_err` = 1. Then send 0x3C with parity bit 0 → `parity_err` = 0.
- **Framing error:** send 0x55 with the stop bit low → `frame_err` = 1 and `data` = 0x55. Then hold the line low 20 bit times → exactly one `break_det` pulse, no further `valid`. On return high, a following 0x12 is received clean.
- **Overrun:** `ready` = 0, send 0x11 then 0x22 back-to-back → `data` stays 0x11 and `overrun` = 1. Raise `ready` → `valid` drops; `overrun` stays 1 until `soft_reset`.
- **Glitch and majority vote:**
  - A 4-tick low glitch on idle → no frame.
  - A 1-tick inverted spike at `sc` = OS/2 inside data bit 3 of 0xF0 → still 0xF0.
- **Mode sweep:** DATA_BITS = 5 with 2 stop bits sends 0x1F. Then `rst` asserted mid-frame → outputs return to reset values and the next frame decodes correctly.
